// File: rtl/mem_arb_pkg.sv
// Shared types and width defaults for the main-memory block-port arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF   = 32;
   localparam int BLOCK_W_DEF  = 256;
   localparam int OFFSET_W_DEF = 5;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_I_RD = 2'd1,
      ST_D_RD = 2'd2,
      ST_D_WR = 2'd3
   } arb_state_e;

   typedef enum logic {
      OWN_I = 1'b0,
      OWN_D = 1'b1
   } owner_e;

endpackage

// File: rtl/mem_block_arbiter_rr_pick2.sv
// Combinational two-way pick between the I-side and D-side requesters.
module rr_pick2
   import mem_arb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1
) (
   input  logic   eligible_i,
   input  logic   eligible_d,
   input  owner_e last_grant,
   output owner_e winner
);

   // On conflict, either alternate away from the last owner or favour D.
   always_comb begin
      winner = OWN_I;
      if (eligible_i && eligible_d) begin
         if (ROUND_ROBIN != 0) begin
            winner = (last_grant == OWN_I) ? OWN_D : OWN_I;
         end else begin
            winner = OWN_D;
         end
      end else if (eligible_d) begin
         winner = OWN_D;
      end else begin
         winner = OWN_I;
      end
   end

endmodule

// File: rtl/mem_block_arbiter.sv
// Serialises I-cache refills and D-cache refills/write-backs onto one memory block port.
// Define MEM_ARB_PERF_CNT_EN to add i_xact_cnt, d_xact_cnt and conflict_cnt outputs.
module mem_block_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ROUND_ROBIN = 1,
   parameter int ADDR_W      = ADDR_W_DEF,
   parameter int BLOCK_W     = BLOCK_W_DEF,
   parameter int OFFSET_W    = OFFSET_W_DEF
) (
   input  logic               CLK,
   input  logic               RESET,
   input  logic               i_req,
   input  logic [ADDR_W-1:0]  i_addr,
   output logic               i_gnt,
   output logic [BLOCK_W-1:0] i_rdata,
   output logic               i_done,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [ADDR_W-1:0]  d_addr,
   input  logic [BLOCK_W-1:0] d_wdata,
   output logic               d_gnt,
   output logic [BLOCK_W-1:0] d_rdata,
   output logic               d_done,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic               mem_blk_read,
   output logic               mem_blk_write,
   output logic [BLOCK_W-1:0] mem_wdata,
   input  logic [BLOCK_W-1:0] mem_rdata,
   input  logic               mem_read_valid,
`ifdef MEM_ARB_PERF_CNT_EN
   output logic [31:0]        i_xact_cnt,
   output logic [31:0]        d_xact_cnt,
   output logic [31:0]        conflict_cnt,
`endif
   input  logic               mem_write_valid
);

   arb_state_e         state_q;
   owner_e             last_grant_q;
   owner_e             winner;
   logic               i_gnt_q, d_gnt_q, i_done_q, d_done_q;
   logic               blk_read_q, blk_write_q;
   logic [ADDR_W-1:0]  mem_addr_q;
   logic [BLOCK_W-1:0] mem_wdata_q, i_rdata_q, d_rdata_q;
   logic               elig_i, elig_d;

   function automatic logic [ADDR_W-1:0] blk_align(input logic [ADDR_W-1:0] a);
      return {a[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
   endfunction

   // A side is not eligible in its own done cycle, so dropping req on done avoids a re-grant.
   assign elig_i = i_req && !i_done_q;
   assign elig_d = d_req && !d_done_q;

   rr_pick2 #(.ROUND_ROBIN(ROUND_ROBIN)) u_pick (
      .eligible_i (elig_i),
      .eligible_d (elig_d),
      .last_grant (last_grant_q),
      .winner     (winner)
   );

   // Arbitration FSM with all requester and memory-side outputs registered.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         state_q      <= ST_IDLE;
         last_grant_q <= OWN_I;
         i_gnt_q      <= 1'b0;
         d_gnt_q      <= 1'b0;
         i_done_q     <= 1'b0;
         d_done_q     <= 1'b0;
         blk_read_q   <= 1'b0;
         blk_write_q  <= 1'b0;
         mem_addr_q   <= '0;
         mem_wdata_q  <= '0;
         i_rdata_q    <= '0;
         d_rdata_q    <= '0;
      end else begin
         i_done_q <= 1'b0;
         d_done_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (elig_i || elig_d) begin
                  if (winner == OWN_D) begin
                     mem_addr_q <= blk_align(d_addr);
                     d_gnt_q    <= 1'b1;
                     if (d_we) begin
                        mem_wdata_q <= d_wdata;
                        blk_write_q <= 1'b1;
                        state_q     <= ST_D_WR;
                     end else begin
                        blk_read_q <= 1'b1;
                        state_q    <= ST_D_RD;
                     end
                  end else begin
                     mem_addr_q <= blk_align(i_addr);
                     i_gnt_q    <= 1'b1;
                     blk_read_q <= 1'b1;
                     state_q    <= ST_I_RD;
                  end
               end
            end
            ST_I_RD: begin
               if (mem_read_valid) begin
                  i_rdata_q    <= mem_rdata;
                  i_done_q     <= 1'b1;
                  i_gnt_q      <= 1'b0;
                  blk_read_q   <= 1'b0;
                  last_grant_q <= OWN_I;
                  state_q      <= ST_IDLE;
               end
            end
            ST_D_RD: begin
               if (mem_read_valid) begin
                  d_rdata_q    <= mem_rdata;
                  d_done_q     <= 1'b1;
                  d_gnt_q      <= 1'b0;
                  blk_read_q   <= 1'b0;
                  last_grant_q <= OWN_D;
                  state_q      <= ST_IDLE;
               end
            end
            ST_D_WR: begin
               if (mem_write_valid) begin
                  d_done_q     <= 1'b1;
                  d_gnt_q      <= 1'b0;
                  blk_write_q  <= 1'b0;
                  last_grant_q <= OWN_D;
                  state_q      <= ST_IDLE;
               end
            end
            default: begin
               i_gnt_q     <= 1'b0;
               d_gnt_q     <= 1'b0;
               blk_read_q  <= 1'b0;
               blk_write_q <= 1'b0;
               state_q     <= ST_IDLE;
            end
         endcase
      end
   end

   assign i_gnt         = i_gnt_q;
   assign d_gnt         = d_gnt_q;
   assign i_done        = i_done_q;
   assign d_done        = d_done_q;
   assign i_rdata       = i_rdata_q;
   assign d_rdata       = d_rdata_q;
   assign mem_addr      = mem_addr_q;
   assign mem_wdata     = mem_wdata_q;
   assign mem_blk_read  = blk_read_q;
   assign mem_blk_write = blk_write_q;

`ifdef MEM_ARB_PERF_CNT_EN
   logic [31:0] i_cnt_q, d_cnt_q, cf_cnt_q;

   // Free-running wrap-around transaction and conflict counters.
   always_ff @(posedge CLK or posedge RESET) begin
      if (RESET) begin
         i_cnt_q  <= 32'd0;
         d_cnt_q  <= 32'd0;
         cf_cnt_q <= 32'd0;
      end else begin
         if (i_done_q) i_cnt_q <= i_cnt_q + 32'd1;
         if (d_done_q) d_cnt_q <= d_cnt_q + 32'd1;
         if ((state_q == ST_IDLE) && elig_i && elig_d) cf_cnt_q <= cf_cnt_q + 32'd1;
      end
   end

   assign i_xact_cnt   = i_cnt_q;
   assign d_xact_cnt   = d_cnt_q;
   assign conflict_cnt = cf_cnt_q;
`endif

endmodule
